secded_rx_decoder: RTL and testbench
====================================

Name: secded_rx_decoder

Overview:
- Serial receive-side decoder for extended Hamming(8,4) SECDED codewords.
- Deserialises a 1-bit-per-cycle code stream arriving from the channel model.
- Corrects single-bit errors, detects double-bit errors and flags framing gaps.
- Keeps saturating error statistics. Pairs with the serial encoder as the SECDED upgrade of the existing Hamming(7,4) receive path.

Parameters:
- MAX_GAP, 4: consecutive idle cycles allowed mid-frame before the partial frame is discarded (range 1..15).
- CNT_W, 8: width of each saturating error counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_in  in  1  code_in carries a valid code bit this cycle.
- code_in  in  1  serial code bit, codeword MSB first (code[7] first, code[0] last).
- sync_in  in  1  frame resync: discard any partial frame.
- cnt_clr  in  1  synchronous clear of both counters.
- valid_out  out  1  one-cycle pulse; all result outputs valid.
- data_out  out  4  decoded data {code[7],code[6],code[5],code[3]} after correction.
- code_out  out  8  corrected codeword (uncorrected on double error).
- single_err  out  1  single error corrected; qualified by valid_out.
- double_err  out  1  uncorrectable double error; qualified by valid_out.
- err_pos  out  3  corrected bit position 0..7; 0 when no correction.
- frame_err  out  1  one-cycle pulse on gap timeout.
- busy  out  1  partial frame in progress (1..7 bits held).
- corr_cnt  out  CNT_W  count of single errors corrected.
- uncorr_cnt  out  CNT_W  count of double errors detected.

Behaviour:
- Codeword layout: code[i] is Hamming position i for i=1..7.
  - Parity bits: p1=code[1], p2=code[2], p4=code[4].
  - Data bits: d1=code[3], d2=code[5], d3=code[6], d4=code[7].
  - code[0] is overall parity = XOR of code[7:1].
- Reset (reset=0, async): all outputs 0, bit counter 0, gap counter 0, FSM in IDLE, pipeline valid cleared.
- Receive FSM, two states:
  - IDLE (0 bits held): a valid_in bit is shifted in, bit count becomes 1, go to SHIFT.
  - SHIFT (1..7 bits held): each valid_in bit is shifted in. On the 8th bit the word is copied into the frame register, frame_vld is set and the FSM returns to IDLE.
- busy = (state == SHIFT).
- Gap timeout:
  - In SHIFT, the gap counter increments on each cycle with valid_in=0 and resets to 0 on each valid bit.
  - When it reaches MAX_GAP: partial frame discarded, frame_err pulses 1 cycle, go to IDLE.
  - Gaps in IDLE are never counted.
- sync_in discards the partial frame and clears the gap counter, with no frame_err.
  - If valid_in is also 1 in that cycle, the bit becomes bit 1 of a new frame (state SHIFT, count 1).
  - sync_in has no effect on the frame register or the decode stage.
- Decode stage:
  - Operates on the frame register: s1=c1^c3^c5^c7, s2=c2^c3^c6^c7, s4=c4^c5^c6^c7, s={s4,s2,s1}, p=XOR(c[7:0]).
  - s==0, p==0: clean, no flags.
  - s!=0, p==1: flip code[s], single_err=1, err_pos=s.
  - s==0, p==1: flip code[0], single_err=1, err_pos=0, data unaffected.
  - s!=0, p==0: double_err=1, err_pos=0, code and data passed uncorrected.
- Latency: the 8th bit is sampled at edge E0. Results are registered at E0+1, and valid_out is high for exactly the cycle after E0+1.
- Result outputs hold their value until the next valid_out.
- Back-to-back frames (64 consecutive valid cycles) are supported with no bubbles. The shift register refills while the previous word is being decoded.
- Counters:
  - Each counter increments by 1 on valid_out with its flag set and saturates at 2^CNT_W-1.
  - cnt_clr has priority over a simultaneous increment; the result is 0.
- Reset asserted mid-frame or mid-decode: everything clears immediately, and no valid_out is produced for the aborted word.

Decomposition:
- Package secded_pkg contains:
  - constants CW_LEN=8, DATA_W=4, SYN_W=3;
  - enum rx_state_t {IDLE, SHIFT};
  - data bit position constants 3, 5, 6, 7.
- Sub-module secded_syndrome: combinational; input code[7:0]; outputs corrected code, data, single_err, double_err, err_pos. It is reusable by a future parallel decoder.

Test Plan:
- Clean frame: serial bits 1,0,1,0,1,0,1,0 (8'hAA) -> valid_out 2 cycles after the last bit, data_out=4'b1011, code_out=8'hAA, no flags.
- Single error, data bit: 8'h8A -> code_out=8'hAA, data_out=4'b1011, single_err=1, err_pos=5, corr_cnt=1.
- Single error, parity bit: 8'hAB -> code_out=8'hAA, single_err=1, err_pos=0.
- Double error: 8'h8E -> double_err=1, single_err=0, data_out=4'b1001, code_out=8'h8E, uncorr_cnt=1.
- Gap timeout: 3 bits, then MAX_GAP (4) idle cycles -> frame_err pulse on the 4th idle cycle, busy=0. A following clean 8'hAA frame then decodes correctly.
- Back-to-back and boundaries, covered as three checks:
  - Eight frames of 8'hAA with no gaps -> eight valid_out pulses 8 cycles apart.
  - CNT_W=2 with five single-error frames -> corr_cnt saturates at 3; cnt_clr together with a sixth error -> 0.
  - sync_in asserted with valid_in mid-frame -> a new frame starts at that bit.

Source files
------------

// File: rtl/secded_pkg.sv
// rtl/secded_pkg.sv - shared constants and types for the SECDED receive path
package secded_pkg;

    localparam int CW_LEN = 8;
    localparam int DATA_W = 4;
    localparam int SYN_W  = 3;

    // Hamming positions carrying the data nibble, d1..d4
    localparam int D1_POS = 3;
    localparam int D2_POS = 5;
    localparam int D3_POS = 6;
    localparam int D4_POS = 7;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

endpackage

// File: rtl/secded_rx_decoder_if.sv
// rtl/secded_rx_decoder_if.sv - serial code stream in, decoded result and statistics out
interface secded_rx_decoder_if #(
    parameter int CNT_W = 8
) ();
    import secded_pkg::*;

    logic                valid_in;
    logic                code_in;
    logic                sync_in;
    logic                cnt_clr;

    logic                valid_out;
    logic [DATA_W-1:0]   data_out;
    logic [CW_LEN-1:0]   code_out;
    logic                single_err;
    logic                double_err;
    logic [SYN_W-1:0]    err_pos;
    logic                frame_err;
    logic                busy;
    logic [CNT_W-1:0]    corr_cnt;
    logic [CNT_W-1:0]    uncorr_cnt;

    modport master (
        output valid_in, code_in, sync_in, cnt_clr,
        input  valid_out, data_out, code_out, single_err, double_err,
               err_pos, frame_err, busy, corr_cnt, uncorr_cnt
    );

    modport slave (
        input  valid_in, code_in, sync_in, cnt_clr,
        output valid_out, data_out, code_out, single_err, double_err,
               err_pos, frame_err, busy, corr_cnt, uncorr_cnt
    );

endinterface

// File: rtl/secded_syndrome.sv
// rtl/secded_syndrome.sv - combinational extended Hamming(8,4) syndrome check and correction
module secded_syndrome
    import secded_pkg::*;
(
    input  logic [CW_LEN-1:0] code,
    output logic [CW_LEN-1:0] code_fix,
    output logic [DATA_W-1:0] data,
    output logic              single_err,
    output logic              double_err,
    output logic [SYN_W-1:0]  err_pos
);

    logic [SYN_W-1:0]  syn;
    logic              parity;
    logic [CW_LEN-1:0] flip_mask;

    // Syndrome points at the faulty Hamming position; overall parity tells odd from even error count
    always_comb begin
        syn[0]     = code[1] ^ code[3] ^ code[5] ^ code[7];
        syn[1]     = code[2] ^ code[3] ^ code[6] ^ code[7];
        syn[2]     = code[4] ^ code[5] ^ code[6] ^ code[7];
        parity     = ^code;
        // syn==0 with odd parity means the overall parity bit itself flipped, so position 0 is right
        flip_mask  = CW_LEN'(1) << syn;
        single_err = parity;
        double_err = (syn != '0) && !parity;
        err_pos    = parity ? syn : '0;
        code_fix   = parity ? (code ^ flip_mask) : code;
        data       = {code_fix[D4_POS], code_fix[D3_POS], code_fix[D2_POS], code_fix[D1_POS]};
    end

endmodule

// File: rtl/secded_rx_decoder.sv
// rtl/secded_rx_decoder.sv - serial SECDED receiver: deserialise, decode, count errors
module secded_rx_decoder
    import secded_pkg::*;
#(
    parameter int MAX_GAP = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    secded_rx_decoder_if.slave rx
);

    localparam logic [3:0]       GAP_LAST = 4'(MAX_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    rx_state_t         state;
    logic [CW_LEN-2:0] sreg;
    logic [2:0]        bit_cnt;
    logic [3:0]        gap_cnt;
    logic [CW_LEN-1:0] frame;
    logic              frame_vld;
    logic              frame_err_r;

    logic [CW_LEN-1:0] dec_code;
    logic [DATA_W-1:0] dec_data;
    logic              dec_single;
    logic              dec_double;
    logic [SYN_W-1:0]  dec_pos;

    logic              valid_r;
    logic [DATA_W-1:0] data_r;
    logic [CW_LEN-1:0] code_r;
    logic              single_r;
    logic              double_r;
    logic [SYN_W-1:0]  pos_r;
    logic [CNT_W-1:0]  corr_r;
    logic [CNT_W-1:0]  uncorr_r;

    // Receive FSM: collect 8 bits MSB first, hand the word to the decode stage, police mid-frame gaps
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            sreg        <= '0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            frame       <= '0;
            frame_vld   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            frame_vld   <= 1'b0;
            frame_err_r <= 1'b0;
            if (rx.sync_in) begin
                // Resync drops the partial frame silently; a coincident bit opens the next frame
                gap_cnt <= '0;
                if (rx.valid_in) begin
                    sreg    <= {sreg[CW_LEN-3:0], rx.code_in};
                    bit_cnt <= 3'd1;
                    state   <= SHIFT;
                end else begin
                    bit_cnt <= '0;
                    state   <= IDLE;
                end
            end else begin
                case (state)
                    IDLE: begin
                        gap_cnt <= '0;
                        if (rx.valid_in) begin
                            sreg    <= {sreg[CW_LEN-3:0], rx.code_in};
                            bit_cnt <= 3'd1;
                            state   <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (rx.valid_in) begin
                            gap_cnt <= '0;
                            if (bit_cnt == 3'd7) begin
                                frame     <= {sreg, rx.code_in};
                                frame_vld <= 1'b1;
                                bit_cnt   <= '0;
                                state     <= IDLE;
                            end else begin
                                sreg    <= {sreg[CW_LEN-3:0], rx.code_in};
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end else if (gap_cnt == GAP_LAST) begin
                            frame_err_r <= 1'b1;
                            gap_cnt     <= '0;
                            bit_cnt     <= '0;
                            state       <= IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + 4'd1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        gap_cnt <= '0;
                    end
                endcase
            end
        end
    end

    secded_syndrome u_syndrome (
        .code       (frame),
        .code_fix   (dec_code),
        .data       (dec_data),
        .single_err (dec_single),
        .double_err (dec_double),
        .err_pos    (dec_pos)
    );

    // Decode stage register: results load one cycle after the frame lands and hold until the next word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r  <= 1'b0;
            data_r   <= '0;
            code_r   <= '0;
            single_r <= 1'b0;
            double_r <= 1'b0;
            pos_r    <= '0;
        end else begin
            valid_r <= frame_vld;
            if (frame_vld) begin
                data_r   <= dec_data;
                code_r   <= dec_code;
                single_r <= dec_single;
                double_r <= dec_double;
                pos_r    <= dec_pos;
            end
        end
    end

    // Saturating error statistics, updated together with the result they describe; clear wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            corr_r   <= '0;
            uncorr_r <= '0;
        end else if (rx.cnt_clr) begin
            corr_r   <= '0;
            uncorr_r <= '0;
        end else if (frame_vld) begin
            if (dec_single && (corr_r != CNT_MAX)) begin
                corr_r <= corr_r + 1'b1;
            end
            if (dec_double && (uncorr_r != CNT_MAX)) begin
                uncorr_r <= uncorr_r + 1'b1;
            end
        end
    end

    assign rx.valid_out  = valid_r;
    assign rx.data_out   = data_r;
    assign rx.code_out   = code_r;
    assign rx.single_err = single_r;
    assign rx.double_err = double_r;
    assign rx.err_pos    = pos_r;
    assign rx.frame_err  = frame_err_r;
    assign rx.busy       = (state == SHIFT);
    assign rx.corr_cnt   = corr_r;
    assign rx.uncorr_cnt = uncorr_r;

endmodule

// File: tb/tb_secded_rx_decoder.sv
// tb/tb_secded_rx_decoder.sv - directed self-checking bench for secded_rx_decoder
module tb_secded_rx_decoder;

    localparam int MAX_GAP = 4;
    localparam int CNT_W   = 2;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    secded_rx_decoder_if #(.CNT_W(CNT_W)) rx ();

    secded_rx_decoder #(.MAX_GAP(MAX_GAP), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx.valid_in = 1'b1;
        rx.code_in  = b;
        tick();
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
        rx.valid_in = 1'b0;
        rx.code_in  = 1'b0;
    endtask

    task automatic decode_check(input string tag, input logic [7:0] w, input logic [7:0] ecode,
                                input logic [3:0] edata, input logic es, input logic ed,
                                input logic [2:0] epos);
        send_word(w);
        check({tag, "_vo_early"}, 32'(rx.valid_out), 32'd0);
        tick();
        check({tag, "_vo"},     32'(rx.valid_out),  32'd1);
        check({tag, "_code"},   32'(rx.code_out),   32'(ecode));
        check({tag, "_data"},   32'(rx.data_out),   32'(edata));
        check({tag, "_single"}, 32'(rx.single_err), 32'(es));
        check({tag, "_double"}, 32'(rx.double_err), 32'(ed));
        check({tag, "_pos"},    32'(rx.err_pos),    32'(epos));
        tick();
        check({tag, "_vo_drop"}, 32'(rx.valid_out), 32'd0);
        check({tag, "_hold"},    32'(rx.code_out),  32'(ecode));
    endtask

    initial begin
        logic [7:0] word;
        int pulses, first_k, last_k, bad_gap, bad_code;

        n_assert    = 0;
        n_fail      = 0;
        reset       = 1'b0;
        rx.valid_in = 1'b0;
        rx.code_in  = 1'b0;
        rx.sync_in  = 1'b0;
        rx.cnt_clr  = 1'b0;
        tick();
        tick();
        check("rst_vo",     32'(rx.valid_out),  32'd0);
        check("rst_busy",   32'(rx.busy),       32'd0);
        check("rst_code",   32'(rx.code_out),   32'd0);
        check("rst_data",   32'(rx.data_out),   32'd0);
        check("rst_ferr",   32'(rx.frame_err),  32'd0);
        check("rst_corr",   32'(rx.corr_cnt),   32'd0);
        check("rst_uncorr", 32'(rx.uncorr_cnt), 32'd0);
        reset = 1'b1;
        tick();

        // Directed decode vectors
        decode_check("clean_aa", 8'hAA, 8'hAA, 4'b1011, 1'b0, 1'b0, 3'd0);
        check("clean_corr", 32'(rx.corr_cnt), 32'd0);
        decode_check("se_d5", 8'h8A, 8'hAA, 4'b1011, 1'b1, 1'b0, 3'd5);
        check("se_d5_corr", 32'(rx.corr_cnt), 32'd1);
        decode_check("se_p0", 8'hAB, 8'hAA, 4'b1011, 1'b1, 1'b0, 3'd0);
        check("se_p0_corr", 32'(rx.corr_cnt), 32'd2);
        decode_check("de", 8'h8E, 8'h8E, 4'b1001, 1'b0, 1'b1, 3'd0);
        check("de_uncorr", 32'(rx.uncorr_cnt), 32'd1);
        check("de_corr",   32'(rx.corr_cnt),   32'd2);
        decode_check("se_d7", 8'h2A, 8'hAA, 4'b1011, 1'b1, 1'b0, 3'd7);
        check("se_d7_corr", 32'(rx.corr_cnt), 32'd3);

        rx.cnt_clr = 1'b1;
        tick();
        rx.cnt_clr = 1'b0;
        check("clr_corr",   32'(rx.corr_cnt),   32'd0);
        check("clr_uncorr", 32'(rx.uncorr_cnt), 32'd0);

        // Gap timeout after 3 bits
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rx.valid_in = 1'b0;
        tick();
        tick();
        tick();
        check("gap3_ferr", 32'(rx.frame_err), 32'd0);
        check("gap3_busy", 32'(rx.busy),      32'd1);
        tick();
        check("gap4_ferr", 32'(rx.frame_err), 32'd1);
        check("gap4_busy", 32'(rx.busy),      32'd0);
        tick();
        check("gap_ferr_pulse", 32'(rx.frame_err), 32'd0);
        decode_check("after_gap", 8'hAA, 8'hAA, 4'b1011, 1'b0, 1'b0, 3'd0);

        // Resync without a bit, then resync carrying the first bit of a new frame
        send_bit(1'b1);
        send_bit(1'b0);
        rx.valid_in = 1'b0;
        rx.sync_in  = 1'b1;
        tick();
        rx.sync_in  = 1'b0;
        check("sync_idle_busy", 32'(rx.busy),      32'd0);
        check("sync_idle_ferr", 32'(rx.frame_err), 32'd0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        word = 8'hAA;
        rx.sync_in = 1'b1;
        send_bit(word[7]);
        rx.sync_in = 1'b0;
        check("sync_bit_busy", 32'(rx.busy), 32'd1);
        for (int i = 6; i >= 0; i--) send_bit(word[i]);
        rx.valid_in = 1'b0;
        tick();
        check("sync_vo",   32'(rx.valid_out),  32'd1);
        check("sync_code", 32'(rx.code_out),   32'h000000AA);
        check("sync_se",   32'(rx.single_err), 32'd0);
        tick();

        // Eight back-to-back frames with no idle cycles
        pulses   = 0;
        first_k  = -1;
        last_k   = -1;
        bad_gap  = 0;
        bad_code = 0;
        for (int k = 1; k <= 66; k++) begin
            if (k <= 64) begin
                rx.valid_in = 1'b1;
                rx.code_in  = word[7 - ((k - 1) % 8)];
            end else begin
                rx.valid_in = 1'b0;
            end
            tick();
            if (rx.valid_out) begin
                pulses++;
                if (first_k < 0) first_k = k;
                else if (k - last_k != 8) bad_gap++;
                last_k = k;
                if (rx.code_out !== 8'hAA || rx.single_err !== 1'b0) bad_code++;
            end
        end
        check("b2b_pulses", 32'(pulses),   32'd8);
        check("b2b_first",  32'(first_k),  32'd9);
        check("b2b_last",   32'(last_k),   32'd65);
        check("b2b_gap",    32'(bad_gap),  32'd0);
        check("b2b_code",   32'(bad_code), 32'd0);

        // Saturation of a 2-bit counter, then clear beating a simultaneous increment
        for (int n = 1; n <= 5; n++) begin
            decode_check("sat", 8'h8A, 8'hAA, 4'b1011, 1'b1, 1'b0, 3'd5);
            check("sat_corr", 32'(rx.corr_cnt), 32'((n < 3) ? n : 3));
        end
        rx.cnt_clr = 1'b1;
        send_word(8'h8A);
        tick();
        check("clr_pri_vo",   32'(rx.valid_out),  32'd1);
        check("clr_pri_se",   32'(rx.single_err), 32'd1);
        check("clr_pri_corr", 32'(rx.corr_cnt),   32'd0);
        rx.cnt_clr = 1'b0;
        tick();
        check("clr_pri_after", 32'(rx.corr_cnt), 32'd0);

        // Reset mid-frame and mid-decode
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        rx.valid_in = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_mid_busy", 32'(rx.busy), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        send_word(8'hAA);
        reset = 1'b0;
        #1;
        check("rst_dec_code", 32'(rx.code_out), 32'd0);
        check("rst_dec_corr", 32'(rx.corr_cnt), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check("rst_dec_vo1", 32'(rx.valid_out), 32'd0);
        tick();
        check("rst_dec_vo2", 32'(rx.valid_out), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
